// File: rtl/iob_eth_mii_rx.sv
`default_nettype none
// ============================================================================
// Module   : iob_eth_mii_rx
// Brief    : MII receive deframer. Strips preamble/SFD, packs nibbles into
//            bytes, streams them with a last-byte marker, and reports
//            per-frame length, FCS and alignment status.
// Revision : 1.0 - initial release
// ============================================================================
module iob_eth_mii_rx #(
    parameter int MIN_PRE_NIBBLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_dv_i,
    input  logic [3:0]  rx_data_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    output logic        last_o,
    output logic        done_o,
    output logic [10:0] len_o,
    output logic        crc_ok_o,
    output logic        err_align_o,
    output logic        err_len_o
);

    localparam logic [1:0]  c_ST_IDLE = 2'd0;
    localparam logic [1:0]  c_ST_PRE  = 2'd1;
    localparam logic [1:0]  c_ST_DATA = 2'd2;
    localparam logic [1:0]  c_ST_DROP = 2'd3;

    // Preamble counter only needs to reach the threshold; it saturates there.
    localparam int          c_CNT_W   = $clog2(MIN_PRE_NIBBLES + 2);
    localparam logic [c_CNT_W-1:0] c_PRE_MIN = c_CNT_W'(MIN_PRE_NIBBLES);

    localparam logic [31:0] c_CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] c_CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] c_CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] c_LEN_MAX     = 11'd2047;
    localparam logic [10:0] c_LEN_MIN_OK  = 11'd64;
    localparam logic [10:0] c_LEN_MAX_OK  = 11'd1518;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_first;       // first cycle after reset release
    logic [c_CNT_W-1:0] r_pre_cnt;
    logic               r_phase;       // 1: low nibble held, expecting high
    logic [3:0]         r_lo;
    logic [7:0]         r_hold;
    logic               r_hold_vld;
    logic [31:0]        r_crc;
    logic [10:0]        r_len;

    logic               w_pre_load;
    logic               w_pre_inc;
    logic               w_start;
    logic               w_lo_take;
    logic               w_byte_done;
    logic               w_eof;
    logic [7:0]         w_byte;

    assign w_byte = {rx_data_i, r_lo};

    // Reflected CRC-32 update of one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ c_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // State register; a frame already in progress at reset release is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_first <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_first <= 1'b0;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_pre_load  = 1'b0;
        w_pre_inc   = 1'b0;
        w_start     = 1'b0;
        w_lo_take   = 1'b0;
        w_byte_done = 1'b0;
        w_eof       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (rx_dv_i) begin
                    if (r_first || (rx_data_i != 4'h5)) begin
                        w_state_nxt = c_ST_DROP;
                    end else begin
                        w_state_nxt = c_ST_PRE;
                        w_pre_load  = 1'b1;
                    end
                end
            end
            c_ST_PRE: begin
                if (!rx_dv_i) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (rx_data_i == 4'h5) begin
                    w_pre_inc = 1'b1;
                end else if ((rx_data_i == 4'hD) && (r_pre_cnt >= c_PRE_MIN)) begin
                    w_state_nxt = c_ST_DATA;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = c_ST_DROP;
                end
            end
            c_ST_DATA: begin
                if (!rx_dv_i) begin
                    w_state_nxt = c_ST_IDLE;
                    w_eof       = 1'b1;
                end else if (!r_phase) begin
                    w_lo_take = 1'b1;
                end else begin
                    w_byte_done = 1'b1;
                end
            end
            c_ST_DROP: begin
                if (!rx_dv_i) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Frame datapath: preamble count, nibble pairing, byte hold, CRC, length.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pre_cnt  <= '0;
            r_phase    <= 1'b0;
            r_lo       <= 4'h0;
            r_hold     <= 8'h00;
            r_hold_vld <= 1'b0;
            r_crc      <= c_CRC_INIT;
            r_len      <= 11'd0;
        end else begin
            if (w_pre_load) begin
                r_pre_cnt <= c_CNT_W'(1);
            end else if (w_pre_inc && (r_pre_cnt != c_PRE_MIN)) begin
                r_pre_cnt <= r_pre_cnt + c_CNT_W'(1);
            end
            if (w_start) begin
                r_phase    <= 1'b0;
                r_hold_vld <= 1'b0;
                r_crc      <= c_CRC_INIT;
                r_len      <= 11'd0;
            end
            if (w_lo_take) begin
                r_lo    <= rx_data_i;
                r_phase <= 1'b1;
            end
            if (w_byte_done) begin
                r_phase    <= 1'b0;
                r_hold     <= w_byte;
                r_hold_vld <= 1'b1;
                r_crc      <= crc32_byte(r_crc, w_byte);
                if (r_len != c_LEN_MAX) begin
                    r_len <= r_len + 11'd1;
                end
            end
            if (w_eof) begin
                r_phase    <= 1'b0;
                r_hold_vld <= 1'b0;
            end
        end
    end

    // Output stage: emit the held byte one byte late, flag the last one at end of frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o      <= 8'h00;
            valid_o     <= 1'b0;
            last_o      <= 1'b0;
            done_o      <= 1'b0;
            len_o       <= 11'd0;
            crc_ok_o    <= 1'b0;
            err_align_o <= 1'b0;
            err_len_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            done_o  <= 1'b0;
            if (w_byte_done && r_hold_vld) begin
                data_o  <= r_hold;
                valid_o <= 1'b1;
            end
            if (w_eof) begin
                if (r_hold_vld) begin
                    data_o  <= r_hold;
                    valid_o <= 1'b1;
                    last_o  <= 1'b1;
                end
                done_o      <= 1'b1;
                len_o       <= r_len;
                crc_ok_o    <= r_hold_vld && (r_crc == c_CRC_RESIDUE);
                err_align_o <= r_phase;
                err_len_o   <= (r_len < c_LEN_MIN_OK) || (r_len > c_LEN_MAX_OK);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/iob_eth_mii_rx.md
# iob_eth_mii_rx

MII receive deframer for the Ethernet path: the receive-side counterpart of the nibble transmit path the FPGA wrappers drive through `ENET_TX_D[3:0]`/`ENET_TX_EN`. It runs in the buffered PHY RX clock domain. It strips preamble and SFD, assembles nibbles into bytes, and streams bytes out with a last-byte marker. It checks the frame FCS (CRC-32), length and nibble alignment, and reports per-frame status for the Ethernet core's receive buffer.

## Interface
- `MIN_PRE_NIBBLES`, default 2: minimum count of 0x5 nibbles required before the SFD nibble 0xD.
- `clk_i` in 1: MII RX clock, i.e. the buffered `ENET_RX_CLK`. All logic is on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `rx_dv_i` in 1: MII RX_DV.
- `rx_data_i` in 4: MII RXD[3:0].
- `data_o` out 8: received byte.
- `valid_o` out 1: `data_o` is valid this cycle. Single-cycle pulse per byte; there is no backpressure.
- `last_o` out 1: qualifies `valid_o`; marks the final byte of the frame, which is the last FCS byte.
- `done_o` out 1: one-cycle end-of-frame pulse; the status outputs are valid in this cycle.
- `len_o` out 11: byte count after SFD, FCS included. Saturates at 2047.
- `crc_ok_o` out 1: FCS check passed.
- `err_align_o` out 1: frame ended on an odd nibble.
- `err_len_o` out 1: `len_o` < 64 or `len_o` > 1518.

## Operation
- States:
  - IDLE: wait for `rx_dv_i`=1. Go to PRE if the nibble is 0x5, else DROP.
  - PRE: count 0x5 nibbles.
    - A nibble of 0xD with count ≥ `MIN_PRE_NIBBLES` → DATA. The SFD nibble itself counts neither as preamble nor as data.
    - A nibble of 0xD with count below `MIN_PRE_NIBBLES` → DROP.
    - Any other nibble → DROP.
    - `rx_dv_i`=0 → IDLE, with no output and no `done_o`.
  - DATA: alternate low nibble, then high nibble. Each high nibble completes a byte `{hi,lo}`.
  - DROP: ignore input until `rx_dv_i`=0, then go to IDLE. No outputs in this state.
- Byte buffering: a completed byte is stored in a one-byte holding register and is only emitted when the next byte completes. This is required so that `last_o` can be attached to the final byte once `rx_dv_i` falls.
- End of frame: the first sampled `rx_dv_i`=0 while in DATA triggers end-of-frame handling.
  - If a byte is held, emit it with `last_o`=1.
  - Pulse `done_o` with the final status. If nothing is held (zero-byte frame), pulse `done_o` with `valid_o`=0.
  - Go to IDLE.
- CRC:
  - Reflected CRC-32: polynomial 0xEDB88320, LSB-first, register initialised to 0xFFFFFFFF on SFD.
  - Each completed byte is folded in on the cycle it completes, FCS bytes included.
  - `crc_ok_o` = (register == 0xDEBB20E3) at end of frame. A zero-byte frame gives `crc_ok_o`=0.
- Length: `len_o` increments per completed byte and saturates at 2047. A dangling odd nibble is not counted.
- Alignment: `err_align_o`=1 if DATA ends after a low nibble without its high nibble. The dangling nibble is discarded.
- Status outputs hold their values until the next `done_o`.
- Reset:
  - All outputs are 0 (`data_o`, `len_o` included) and the state goes to IDLE.
  - If `rx_dv_i`=1 in the first cycle after reset is released, go to DROP. The block never resynchronises mid-frame.
  - Reset mid-frame discards the frame with no `done_o`.
- `rx_dv_i` falling in the same cycle a high nibble would arrive: that nibble is invalid, so the frame ends after the low nibble and is flagged as alignment error.

## Timing
- Input is sampled every rising edge of `clk_i`.
- Byte n completes at edge E (high nibble sampled). It is emitted with `valid_o`=1 during the cycle following the edge at which byte n+1 completes.
- If `rx_dv_i`=0 is first sampled at edge F, then `valid_o`/`last_o` (final byte) and `done_o` are all asserted during the cycle after F, together with valid status.
- `valid_o` has at least one idle cycle between pulses, since a byte takes two nibble cycles.
- A new frame may begin the cycle after `done_o`; there is no IFG requirement.

## Test plan
- **Known CRC vector.** Stimulus: 7 bytes 0x55, SFD 0xD5, payload ASCII "123456789", FCS bytes 26 39 F4 CB, all low nibble first. Required: 13 `valid_o` pulses carrying 31…39 26 39 F4 CB, with `last_o` on 0xCB; `done_o` with `len_o`=13, `crc_ok_o`=1, `err_len_o`=1, `err_align_o`=0.
- **Minimum frame.** Stimulus: 60-byte payload 0x00–0x3B plus correct FCS. Required: `len_o`=64, `crc_ok_o`=1, `err_len_o`=0.
- **FCS corruption.** Stimulus: the same 64-byte frame with one payload bit flipped. Required: `crc_ok_o`=0; all 64 bytes are still streamed out.
- **Odd nibble.** Stimulus: the 13-byte frame followed by one extra nibble 0xA. Required: `len_o`=13, `err_align_o`=1, `crc_ok_o`=1; `last_o` on 0xCB.
- **Bad preamble.** Stimulus: 0x5, 0x5, 0x7, then a valid SFD and 20 bytes before `rx_dv_i` falls. Required: no `valid_o` and no `done_o`. A following good frame is received correctly.
- **Reset mid-frame.** Stimulus: assert `rst_i` for 1 cycle at byte 10 while `rx_dv_i` stays high. Required: all outputs 0, no `done_o`, the remainder of the frame is dropped, and the next frame is received with `crc_ok_o`=1.
